// File: rtl/fuzz_vector_sequencer.sv
// fuzz_vector_sequencer: buffers stimulus vectors, replays them onto a fuzz DUT, captures y, optional MISR (macro FUZZ_SEQ_MISR_EN); ports: clk, rst, load_valid/ready/data, clear, start, busy, done, dut_in, dut_out, cap_valid/data, sig
module fuzz_vector_sequencer #(
  parameter int VEC_W = 64,
  parameter int OUT_W = 199,
  parameter int DEPTH = 32,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [VEC_W-1:0] load_data,
  input  logic             clear,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             cap_valid,
  output logic [OUT_W-1:0] cap_data,
  output logic [31:0]      sig
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CAPTURE, S_DONE} state_t;
  state_t state, state_n;
  logic [VEC_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [CW-1:0] count, len, idx;
  logic [SW-1:0] scnt;
  logic accept, go, run_go, last;
  assign load_ready = state == S_IDLE && count < CW'(DEPTH);
  assign accept = load_valid && load_ready && !clear;
  assign go = state == S_IDLE && start && !clear;
  // a load accepted alongside start joins the run, so an empty buffer plus a load is not an empty run
  assign run_go = go && (count != '0 || accept);
  assign last = idx == len - 1'b1;
  assign done = state == S_DONE;
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = go ? (run_go ? S_APPLY : S_DONE) : S_IDLE;
      S_APPLY:   state_n = SETTLE == 0 ? S_CAPTURE : S_SETTLE;
      S_SETTLE:  state_n = 32'(scnt) == SETTLE - 1 ? S_CAPTURE : S_SETTLE;
      S_CAPTURE: state_n = last ? S_DONE : S_APPLY;
      default:   state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (accept) mem[wptr] <= load_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      count <= '0;
      len <= '0;
      idx <= '0;
      scnt <= '0;
      busy <= 1'b0;
      cap_valid <= 1'b0;
      cap_data <= '0;
      dut_in <= '0;
    end else begin
      cap_valid <= state == S_CAPTURE;
      scnt <= state == S_SETTLE ? scnt + 1'b1 : '0;
      if (clear && state == S_IDLE) begin
        wptr <= '0;
        count <= '0;
      end else if (accept) begin
        wptr <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (go) begin
        len <= count + CW'(accept);
        idx <= '0;
      end
      if (run_go) busy <= 1'b1;
      else if (state == S_DONE) busy <= 1'b0;
      if (state == S_APPLY) dut_in <= mem[idx[AW-1:0]];
      if (state == S_CAPTURE) begin
        cap_data <= dut_out;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
`ifdef FUZZ_SEQ_MISR_EN
  localparam int NCH = (OUT_W + 31) / 32;
  logic [NCH*32-1:0] ext;
  logic [31:0] fold;
  always_comb begin
    ext = '0;
    ext[OUT_W-1:0] = dut_out;
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ ext[i*32+:32];
  end
  always_ff @(posedge clk) begin
    if (rst || run_go) sig <= '0;
    else if (state == S_CAPTURE) sig <= {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
  end
`else
  assign sig = '0;
`endif
endmodule
